// File: rtl/spi_debug_master_if.sv
// Write-request channel into the SPI debug master: one (addr, data) pair per
// valid/ready handshake on sys_clk.
interface spi_debug_master_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/spi_debug_master.sv
// SPI initiator for the slave-side debug write port. Each frame is a run of
// GAP pulses with CS deasserted (they realign the slave bit counter), then CS
// low, the address byte, one or more data bytes, and CS high. Bits go out LSB
// first and are sampled by the slave on the rising edge of spi_clk.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | CS high, SCLK low, waiting for a write request
// GAP    | CS high, emitting GAP_PULSES SCLK pulses to reset the slave
// SETUP  | CS low, SCLK low for one half-period, address LSB on MOSI
// SHIFT  | shifting out the address+data (16 bits) or burst data (8 bits)
// DECIDE | one cycle: extend the frame with a same-address write, or close
module spi_debug_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_PULSES = 1,
  parameter bit          BURST_EN   = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  spi_debug_master_if.slave  wr,
  output logic               busy,
  output logic               spi_clk,
  output logic               spi_cs_o,
  output logic               spi_data_o
);

  typedef enum logic [2:0] {IDLE, GAP, SETUP, SHIFT, DECIDE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]  GAP_LAST = 4'(GAP_PULSES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] div_cnt;
  logic        phase;       // 0 = SCLK low half, 1 = SCLK high half
  logic [3:0]  pulse_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_q;
  logic [7:0]  cur_addr;
  logic [7:0]  cur_data;
  logic        div_end;
  logic        burst_hit;
  logic        accept;

  assign div_end    = (div_cnt == DIV_LAST);
  assign burst_hit  = BURST_EN && wr.wr_valid && (wr.wr_addr == cur_addr);
  assign wr.wr_ready = (state == IDLE) || ((state == DECIDE) && burst_hit);
  assign accept     = wr.wr_valid && wr.wr_ready;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode; phase transitions happen at the end of a high half.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = GAP;
      GAP:     if (div_end && phase && (pulse_cnt == GAP_LAST)) state_nxt = SETUP;
      SETUP:   if (div_end) state_nxt = SHIFT;
      SHIFT:   if (div_end && phase && (bit_cnt == 5'd1)) state_nxt = DECIDE;
      DECIDE:  state_nxt = burst_hit ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider, pulse/bit counters, shift register and latched request.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt   <= '0;
      phase     <= 1'b0;
      pulse_cnt <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      cur_addr  <= '0;
      cur_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt   <= '0;
          phase     <= 1'b0;
          pulse_cnt <= '0;
          if (accept) begin
            cur_addr <= wr.wr_addr;
            cur_data <= wr.wr_data;
          end
        end
        GAP: begin
          if (div_end) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) pulse_cnt <= pulse_cnt + 4'd1;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            shift_q <= {cur_data, cur_addr};
            bit_cnt <= 5'd16;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            phase   <= ~phase;
            // Advance only as SCLK falls so MOSI never moves while SCLK is high.
            if (phase) begin
              shift_q <= {1'b0, shift_q[15:1]};
              bit_cnt <= bit_cnt - 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DECIDE: begin
          div_cnt <= '0;
          phase   <= 1'b0;
          if (burst_hit) begin
            cur_data <= wr.wr_data;
            shift_q  <= {8'h00, wr.wr_data};
            bit_cnt  <= 5'd8;
          end
        end
        default: begin
          div_cnt <= '0;
          phase   <= 1'b0;
        end
      endcase
    end
  end

  // Pin decode from state; DECIDE presents the burst byte's LSB a cycle early.
  always_comb begin
    busy       = (state != IDLE);
    spi_clk    = 1'b0;
    spi_cs_o   = 1'b1;
    spi_data_o = 1'b0;
    case (state)
      GAP: spi_clk = phase;
      SETUP: begin
        spi_cs_o   = 1'b0;
        spi_data_o = cur_addr[0];
      end
      SHIFT: begin
        spi_cs_o   = 1'b0;
        spi_clk    = phase;
        spi_data_o = shift_q[0];
      end
      DECIDE: begin
        spi_cs_o   = 1'b0;
        spi_data_o = burst_hit ? wr.wr_data[0] : 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_debug_master.sv
// Bench for spi_debug_master: three differently parameterised instances share
// one stimulus path selected by 'sel'; a behavioural debug slave decodes MOSI.
module tb_spi_debug_master;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] sel = 2'd0;

  logic [2:0] clk_v, cs_v, dat_v, busy_v;
  logic       mon_clk, mon_cs, mon_data, mon_busy, mon_rdy;

  always #5 sys_clk = ~sys_clk;

  spi_debug_master_if if0 ();
  spi_debug_master_if if1 ();
  spi_debug_master_if if2 ();

  assign if0.wr_valid = wr_valid && (sel == 2'd0);
  assign if1.wr_valid = wr_valid && (sel == 2'd1);
  assign if2.wr_valid = wr_valid && (sel == 2'd2);
  assign if0.wr_addr = wr_addr;
  assign if1.wr_addr = wr_addr;
  assign if2.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;
  assign if1.wr_data = wr_data;
  assign if2.wr_data = wr_data;

  spi_debug_master #(.CLK_DIV(2), .GAP_PULSES(1), .BURST_EN(1'b1)) u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr(if0), .busy(busy_v[0]),
    .spi_clk(clk_v[0]), .spi_cs_o(cs_v[0]), .spi_data_o(dat_v[0]));
  spi_debug_master #(.CLK_DIV(3), .GAP_PULSES(2), .BURST_EN(1'b0)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr(if1), .busy(busy_v[1]),
    .spi_clk(clk_v[1]), .spi_cs_o(cs_v[1]), .spi_data_o(dat_v[1]));
  spi_debug_master #(.CLK_DIV(1), .GAP_PULSES(3), .BURST_EN(1'b1)) u2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr(if2), .busy(busy_v[2]),
    .spi_clk(clk_v[2]), .spi_cs_o(cs_v[2]), .spi_data_o(dat_v[2]));

  assign mon_clk  = clk_v[sel];
  assign mon_cs   = cs_v[sel];
  assign mon_data = dat_v[sel];
  assign mon_busy = busy_v[sel];
  assign mon_rdy  = (sel == 2'd0) ? if0.wr_ready : (sel == 2'd1) ? if1.wr_ready : if2.wr_ready;

  // Behavioural debug slave: pulses with CS high clear the bit counter and arm
  // the address flag; with CS low, bytes arrive LSB first.
  int         gap_cnt = 0;
  int         frames = 0;
  int         bit_n = 0;
  int         acc_cnt = 0;
  int         viol = 0;
  logic       addr_flag = 1'b0;
  logic [7:0] m_sh = 8'h00;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  logic       bits_q[$];

  always @(posedge mon_clk) begin
    if (mon_cs) begin
      gap_cnt++;
      bit_n = 0;
      addr_flag = 1'b1;
    end else begin
      bits_q.push_back(mon_data);
      m_sh = {mon_data, m_sh[7:1]};
      bit_n++;
      if (bit_n == 8) begin
        bit_n = 0;
        if (addr_flag) begin
          m_addr = m_sh;
          addr_flag = 1'b0;
        end else begin
          wa.push_back(m_addr);
          wd.push_back(m_sh);
        end
      end
    end
  end

  always @(negedge mon_cs) frames++;

  always @(posedge sys_clk) if (wr_valid && mon_rdy) acc_cnt++;

  // MOSI must not move on or during the high phase of SCLK inside a frame.
  logic p_cs = 1'b1;
  logic p_data = 1'b0;
  always @(posedge sys_clk) begin
    #3;
    if (!mon_cs && !p_cs && mon_clk && (mon_data !== p_data)) viol++;
    p_cs = mon_cs;
    p_data = mon_data;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge sys_clk);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    #1;
    while (!mon_rdy && n < 5000) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    if (!mon_rdy) begin
      timeout_fail("send");
      wr_valid = 1'b0;
      return;
    end
    @(posedge sys_clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mon_busy || !mon_cs) && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 20000) timeout_fail("wait_idle");
    @(negedge sys_clk);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] data;
    int         cycles;  // accept edge to CS high: 2*D*G + D + 32*D + 1
    int         gaps;
  } vec_t;

  vec_t vt[6];
  logic [7:0] ea[$];
  logic [7:0] ed[$];

  initial begin
    int g0, f0, w0, a0, b0, n, seen;
    logic [15:0] seq;

    vt[0] = '{2'd0, 8'h12, 8'h34, 71, 1};
    vt[1] = '{2'd0, 8'hA5, 8'h5A, 71, 1};
    vt[2] = '{2'd1, 8'h12, 8'h34, 112, 2};
    vt[3] = '{2'd1, 8'hFF, 8'h00, 112, 2};
    vt[4] = '{2'd2, 8'h3C, 8'hC3, 40, 3};
    vt[5] = '{2'd2, 8'h01, 8'h80, 40, 3};

    // Reset values on every instance.
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_cs", {31'd0, mon_cs}, 32'd1);
      chk("rst_clk", {31'd0, mon_clk}, 32'd0);
      chk("rst_data", {31'd0, mon_data}, 32'd0);
      chk("rst_busy", {31'd0, mon_busy}, 32'd0);
    end
    sel = 2'd0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single writes: latency, GAP pulse count, MOSI order and slave decode.
    for (int i = 0; i < 6; i++) begin
      sel = vt[i].sel;
      @(negedge sys_clk);
      g0 = gap_cnt; w0 = wa.size(); b0 = bits_q.size();
      send(vt[i].addr, vt[i].data);
      n = 0; seen = 0;
      while (n < 2000) begin
        @(posedge sys_clk);
        #1;
        n++;
        if (!mon_cs) seen = 1;
        else if (seen != 0) break;
      end
      chk("single_cycles", n, vt[i].cycles);
      chk("single_gaps", gap_cnt - g0, vt[i].gaps);
      chk("single_nwr", wa.size() - w0, 1);
      if (wa.size() > w0) chk("single_wr", {wa[w0], wd[w0]}, {vt[i].addr, vt[i].data});
      // seq[k] is the k-th bit seen at a rising edge: addr LSB first, then data.
      seq = '0;
      for (int k = 0; k < 16; k++) if (b0 + k < bits_q.size()) seq[k] = bits_q[b0 + k];
      chk("single_bits", {16'd0, seq}, {16'd0, vt[i].data, vt[i].addr});
      wait_idle();
    end

    // Burst to one address: one GAP, one address byte, three data bytes.
    sel = 2'd0;
    g0 = gap_cnt; f0 = frames; w0 = wa.size(); a0 = acc_cnt;
    send(8'h40, 8'hA1);
    send(8'h40, 8'hA2);
    send(8'h40, 8'hA3);
    wait_idle();
    chk("burst_frames", frames - f0, 1);
    chk("burst_gaps", gap_cnt - g0, 1);
    chk("burst_accepts", acc_cnt - a0, 3);
    chk("burst_nwr", wa.size() - w0, 3);
    for (int k = 0; k < 3; k++)
      if (wa.size() > w0 + k) chk("burst_wr", {wa[w0 + k], wd[w0 + k]}, {8'h40, 8'hA1 + 8'(k)});

    // Address change closes the frame; the next write gets its own frame.
    g0 = gap_cnt; f0 = frames; w0 = wa.size();
    send(8'h05, 8'h11);
    send(8'h06, 8'h22);
    wait_idle();
    chk("achg_frames", frames - f0, 2);
    chk("achg_gaps", gap_cnt - g0, 2);
    chk("achg_nwr", wa.size() - w0, 2);
    if (wa.size() > w0 + 1) begin
      chk("achg_wr0", {wa[w0], wd[w0]}, 16'h0511);
      chk("achg_wr1", {wa[w0 + 1], wd[w0 + 1]}, 16'h0622);
    end

    // Bursting disabled: a same-address pair is two full frames.
    sel = 2'd1;
    g0 = gap_cnt; f0 = frames; w0 = wa.size();
    send(8'h33, 8'h44);
    send(8'h33, 8'h55);
    wait_idle();
    chk("noburst_frames", frames - f0, 2);
    chk("noburst_gaps", gap_cnt - g0, 4);
    chk("noburst_nwr", wa.size() - w0, 2);
    if (wa.size() > w0 + 1) chk("noburst_wr1", {wa[w0 + 1], wd[w0 + 1]}, 16'h3355);

    // Backpressure: request held valid, addr/data change every cycle until taken.
    sel = 2'd0;
    w0 = wa.size();
    ea.delete(); ed.delete();
    for (int k = 0; k < 50; k++) begin
      int acc = 0;
      n = 0;
      @(negedge sys_clk);
      wr_valid = 1'b1;
      while (acc == 0 && n < 5000) begin
        wr_addr = 8'h20 + 8'($urandom_range(0, 1));
        wr_data = 8'($urandom);
        #1;
        if (mon_rdy) begin
          acc = 1;
          ea.push_back(wr_addr);
          ed.push_back(wr_data);
          @(posedge sys_clk);
          #1;
        end else begin
          @(negedge sys_clk);
          n++;
        end
      end
      if (acc == 0) timeout_fail("bp_send");
    end
    wr_valid = 1'b0;
    wait_idle();
    chk("bp_nwr", wa.size() - w0, ea.size());
    for (int k = 0; k < ea.size(); k++)
      if (wa.size() > w0 + k) chk("bp_wr", {wa[w0 + k], wd[w0 + k]}, {ea[k], ed[k]});

    // Reset in the middle of the address byte, then a clean write.
    send(8'h55, 8'h66);
    n = 0;
    while (!(!mon_cs && addr_flag && bit_n == 5) && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 2000) timeout_fail("rst_mid_wait");
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rstmid_clk", {31'd0, mon_clk}, 32'd0);
    chk("rstmid_cs", {31'd0, mon_cs}, 32'd1);
    chk("rstmid_busy", {31'd0, mon_busy}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    w0 = wa.size();
    send(8'h7F, 8'h80);
    wait_idle();
    chk("rstmid_nwr", wa.size() - w0, 1);
    if (wa.size() > w0) chk("rstmid_wr", {wa[w0], wd[w0]}, 16'h7F80);

    // Burst on the fastest divider with three GAP pulses.
    sel = 2'd2;
    g0 = gap_cnt; f0 = frames; w0 = wa.size();
    send(8'h9A, 8'h01);
    send(8'h9A, 8'hFE);
    wait_idle();
    chk("fast_gaps", gap_cnt - g0, 3);
    chk("fast_frames", frames - f0, 1);
    if (wa.size() > w0 + 1) chk("fast_wr1", {wa[w0 + 1], wd[w0 + 1]}, 16'h9AFE);
    else chk("fast_nwr", wa.size() - w0, 2);

    chk("mosi_stable_high", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
